// File: rtl/lsu_memif_if.sv
// Bundle of the pipeline request/response handshake and the data-memory beat port.
// The master modport is the load/store unit; the slave modport is the pipeline plus memory.
interface lsu_memif_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_memif.sv
// Load/store unit: issues aligned word beats for one request at a time, splitting
// word-crossing accesses into two beats, and returns extended load data or an error.
module lsu_memif #(
  parameter int unsigned pMEM_BYTES   = 512,
  parameter bit          pALLOW_SPLIT = 1'b1
) (
  input  logic        clk,
  input  logic        iwnRst,
  lsu_memif_if.master bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_e;
  state_e state_q, state_d;

  logic [DW-1:0] ra_q, rd_q, rlo_q;
  logic [3:0]    rop_q;

  logic [DW-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic [SW-1:0] mem_wstrb_q, mem_wstrb_d;
  logic          resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic          req_ready_q, req_ready_d;

  logic          accept;
  logic [DW-1:0] cur_addr, cur_data, word_base, lo_word, load_result;
  logic [3:0]    cur_op;
  logic [1:0]    off;
  logic [2:0]    nbytes;
  logic [SW-1:0] bmask;
  logic          split, err;
  logic [DW:0]   last_byte;
  logic [2*DW-1:0] wide_data, load_shift;
  logic [2*SW-1:0] wide_strb;

  // In IDLE decode the incoming request so the first beat is ready right after accept.
  assign accept   = (state_q == IDLE) && bus.req_valid && req_ready_q;
  assign cur_addr = (state_q == IDLE) ? bus.req_addr  : ra_q;
  assign cur_data = (state_q == IDLE) ? bus.req_wdata : rd_q;
  assign cur_op   = (state_q == IDLE) ? bus.req_op    : rop_q;

  always_comb begin
    nbytes = 3'd4;
    bmask  = 4'b1111;
    case (cur_op[1:0])
      2'b00:   begin nbytes = 3'd1; bmask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; bmask = 4'b0011; end
      default: begin nbytes = 3'd4; bmask = 4'b1111; end
    endcase
    off        = cur_addr[1:0];
    split      = (4'(off) + 4'(nbytes)) > 4'd4;
    last_byte  = 33'(cur_addr) + 33'(nbytes) - 33'd1;
    err        = (cur_op[1:0] == 2'b11) || (last_byte >= 33'(pMEM_BYTES)) ||
                 (split && !pALLOW_SPLIT);
    word_base  = {cur_addr[31:2], 2'b00};
    wide_data  = 64'(cur_data) << {off, 3'b000};
    wide_strb  = 8'(bmask) << off;
  end

  // Load merge: low word is live in ACC0, captured by the time ACC1 reads the high word.
  always_comb begin
    lo_word    = (state_q == ACC1) ? rlo_q : bus.mem_rdata;
    load_shift = {bus.mem_rdata, lo_word} >> {off, 3'b000};
    case (cur_op[1:0])
      2'b00:   load_result = cur_op[2] ? 32'(load_shift[7:0])
                                       : {{24{load_shift[7]}}, load_shift[7:0]};
      2'b01:   load_result = cur_op[2] ? 32'(load_shift[15:0])
                                       : {{16{load_shift[15]}}, load_shift[15:0]};
      default: load_result = load_shift[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge iwnRst) begin
    if (!iwnRst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = err ? RESP : ACC0;
      ACC0: state_d = split ? ACC1 : RESP;
      ACC1: state_d = RESP;
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the transition being taken.
  always_comb begin
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = '0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    resp_valid_d = (state_d == RESP);
    req_ready_d  = (state_d == IDLE);
    case (state_q)
      IDLE: if (accept) begin
        if (err) begin
          resp_err_d  = 1'b1;
          resp_data_d = '0;
        end else begin
          mem_addr_d = word_base;
          if (cur_op[3]) begin
            mem_wdata_d = wide_data[31:0];
            mem_wstrb_d = wide_strb[3:0];
          end
        end
      end
      ACC0: if (split) begin
        mem_addr_d = word_base + 32'd4;
        if (cur_op[3]) begin
          mem_wdata_d = wide_data[63:32];
          mem_wstrb_d = wide_strb[7:4];
        end
      end else begin
        resp_err_d  = 1'b0;
        resp_data_d = cur_op[3] ? '0 : load_result;
      end
      ACC1: begin
        resp_err_d  = 1'b0;
        resp_data_d = cur_op[3] ? '0 : load_result;
      end
      RESP: if (bus.resp_ready) begin
        resp_err_d  = 1'b0;
        resp_data_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge iwnRst) begin
    if (!iwnRst) begin
      ra_q         <= '0;
      rd_q         <= '0;
      rop_q        <= '0;
      rlo_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      if (accept) begin
        ra_q  <= bus.req_addr;
        rd_q  <= bus.req_wdata;
        rop_q <= bus.req_op;
      end
      if (state_q == ACC0) rlo_q <= bus.mem_rdata;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
endmodule

// File: tb/tb_lsu_memif.sv
// Directed bench for lsu_memif against a 512-byte little-endian memory model.
module tb_lsu_memif;
  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_BAD = 4'b0011;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  logic clk = 1'b0;
  logic iwnRst;
  always #5 clk = ~clk;

  lsu_memif_if bus ();

  lsu_memif dut (
    .clk   (clk),
    .iwnRst(iwnRst),
    .bus   (bus)
  );

  logic [7:0] mem [0:511];
  logic       poke_en = 1'b0;
  logic [8:0] poke_addr = '0;
  logic [7:0] poke_data = '0;

  always_comb begin
    if (bus.mem_addr < 32'd509)
      bus.mem_rdata = {mem[9'(bus.mem_addr + 32'd3)], mem[9'(bus.mem_addr + 32'd2)],
                       mem[9'(bus.mem_addr + 32'd1)], mem[9'(bus.mem_addr)]};
    else
      bus.mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    for (int i = 0; i < 4; i++)
      if (bus.mem_wstrb[i] && bus.mem_addr < 32'd509)
        mem[9'(bus.mem_addr + 32'(i))] <= bus.mem_wdata[8*i +: 8];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic [31:0] b0_addr, b0_wdata, b1_addr, b1_wdata;
  logic [3:0]  b0_strb, b1_strb, strb_seen;
  logic [31:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    #1 poke_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE and return just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Count cycles to resp_valid from the accepting edge, recording the beats seen.
  task automatic wait_resp();
    lat = 1;
    b0_addr = bus.mem_addr; b0_strb = bus.mem_wstrb; b0_wdata = bus.mem_wdata;
    b1_addr = '0; b1_strb = '0; b1_wdata = '0;
    strb_seen = bus.mem_wstrb;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 2) begin
        b1_addr = bus.mem_addr; b1_strb = bus.mem_wstrb; b1_wdata = bus.mem_wdata;
      end
      strb_seen = strb_seen | bus.mem_wstrb;
    end
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    iwnRst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    poke(9'h010, 8'h44); poke(9'h011, 8'h33); poke(9'h012, 8'h22); poke(9'h013, 8'h11);
    poke(9'h020, 8'hA5); poke(9'h021, 8'h5A);
    @(negedge clk);
    iwnRst = 1'b1;
    @(posedge clk);
    #1;

    // Aligned word load
    send(OP_LW, 32'h10, 32'h0);
    chk("lw_ready_low", 32'(bus.req_ready), 32'd0);
    wait_resp();
    chk("lw_acc0_addr", b0_addr, 32'h10);
    chk("lw_latency", 32'(lat), 32'd2);
    chk("lw_data", bus.resp_data, 32'h11223344);
    chk("lw_err", 32'(bus.resp_err), 32'd0);
    chk("lw_no_strb", 32'(strb_seen), 32'd0);
    ack();
    chk("lw_valid_drop", 32'(bus.resp_valid), 32'd0);
    chk("lw_ready_back", 32'(bus.req_ready), 32'd1);

    // Sign/zero extension
    poke(9'h013, 8'h80);
    send(OP_LB, 32'h13, 32'h0); wait_resp();
    chk("lb_data", bus.resp_data, 32'hFFFFFF80); ack();
    send(OP_LBU, 32'h13, 32'h0); wait_resp();
    chk("lbu_data", bus.resp_data, 32'h00000080); ack();
    send(OP_LH, 32'h12, 32'h0); wait_resp();
    chk("lh_data", bus.resp_data, 32'hFFFF8022); ack();

    // Word-crossing halfword store then load
    send(OP_SH, 32'h0F, 32'h0000BEEF); wait_resp();
    chk("sh_b0_addr", b0_addr, 32'h0C);
    chk("sh_b0_strb", 32'(b0_strb), 32'h8);
    chk("sh_b0_byte", 32'(b0_wdata[31:24]), 32'hEF);
    chk("sh_b1_addr", b1_addr, 32'h10);
    chk("sh_b1_strb", 32'(b1_strb), 32'h1);
    chk("sh_b1_byte", 32'(b1_wdata[7:0]), 32'hBE);
    chk("sh_latency", 32'(lat), 32'd3);
    chk("sh_data", bus.resp_data, 32'h0);
    chk("sh_err", 32'(bus.resp_err), 32'd0);
    ack();
    send(OP_LHU, 32'h0F, 32'h0); wait_resp();
    chk("lhu_split_data", bus.resp_data, 32'h0000BEEF);
    chk("lhu_split_latency", 32'(lat), 32'd3);
    ack();

    // Errors: out of range and illegal size
    send(OP_LW, 32'h1FE, 32'h0); wait_resp();
    chk("oor_err", 32'(bus.resp_err), 32'd1);
    chk("oor_latency", 32'(lat), 32'd1);
    chk("oor_data", bus.resp_data, 32'h0);
    chk("oor_no_strb", 32'(strb_seen), 32'd0);
    ack();
    send(OP_BAD, 32'h10, 32'h0); wait_resp();
    chk("size_err", 32'(bus.resp_err), 32'd1);
    chk("size_latency", 32'(lat), 32'd1);
    ack();
    chk("err_cleared", 32'(bus.resp_err), 32'd0);

    // Response backpressure with a pending request that must wait
    send(OP_LW, 32'h10, 32'h0); wait_resp();
    held = bus.resp_data;
    chk("hold_data0", held, 32'h802233BE);
    bus.req_valid = 1'b1; bus.req_op = OP_LBU; bus.req_addr = 32'h11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_data", bus.resp_data, 32'h802233BE);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    ack();
    chk("nobypass_valid", 32'(bus.resp_valid), 32'd0);
    chk("nobypass_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_resp();
    chk("next_latency", 32'(lat), 32'd2);
    chk("next_data", bus.resp_data, 32'h00000033);
    ack();

    // Reset in the second beat of a split word store
    send(OP_SW, 32'h1E, 32'hCAFEF00D);
    chk("sw_acc0_strb", 32'(bus.mem_wstrb), 32'hC);
    @(posedge clk);
    #1;
    chk("sw_acc1_addr", bus.mem_addr, 32'h20);
    chk("sw_acc1_strb", 32'(bus.mem_wstrb), 32'h3);
    #1 iwnRst = 1'b0;
    #1;
    chk("rst_mid_strb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    #1 iwnRst = 1'b1;
    chk("mem20_kept", 32'(mem[9'h020]), 32'hA5);
    chk("mem21_kept", 32'(mem[9'h021]), 32'h5A);
    chk("mem1e_written", 32'(mem[9'h01E]), 32'h0D);
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
